// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
//
// Purpose: operation and state enumerations plus the default datapath width.
// The control FSM and the instruction decoder import mdu_op_t from here.
package muldiv_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO
//
// Purpose: shift-add multiply and restoring divide, one bit per CALC cycle,
// sharing a single 2*WIDTH accumulator and iteration counter.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, op           command strobe and opcode, sampled only in IDLE
//   srca, srcb          multiplicand/dividend, multiplier/divisor
//   hilo_we/sel/wdata   direct MTHI/MTLO write, honoured only in IDLE without start
//   busy, done          registered status; done pulses one cycle with new HI/LO
//   hi, lo              architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_t         state;
  mdu_op_t            op_r;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   orig_a;
  logic [CW-1:0]      count;
  logic               sa, sb;

  // Operand capture: signed ops keep magnitudes plus signs.
  logic             start_signed;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    start_signed = (op == MULT) || (op == DIV);
    mag_a = (start_signed && srca[WIDTH-1]) ? -srca : srca;
    mag_b = (start_signed && srcb[WIDTH-1]) ? -srcb : srcb;
  end

  // One iteration step for each algorithm.
  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend bits}; the trial
  //           subtraction uses WIDTH+1 bits so the bit shifted out is kept.
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    add_sum  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb})
                      : {1'b0, acc[2*WIDTH-1:WIDTH]};
    mul_next = {add_sum, acc[WIDTH-1:1]};
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up and final HI/LO values, consumed at the FIX edge.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod = (op_r == MULT && (sa ^ sb)) ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (op_r == DIV) begin
      if (sa ^ sb) quo = -quo;
      if (sa)      rem = -rem;
    end
    if (!op_r[1]) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (opb == '0) begin
      fix_hi = orig_a;
      fix_lo = '1;
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_r   <= MULT;
      acc    <= '0;
      opb    <= '0;
      orig_a <= '0;
      count  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // start has priority; a simultaneous direct write is dropped
            op_r   <= mdu_op_t'(op);
            sa     <= start_signed & srca[WIDTH-1];
            sb     <= start_signed & srcb[WIDTH-1];
            orig_a <= srca;
            opb    <= mag_b;
            acc    <= {{WIDTH{1'b0}}, mag_a};
            count  <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else if (hilo_we) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
          end
        end
        CALC: begin
          acc   <= op_r[1] ? div_next : mul_next;
          count <= count + CW'(1);
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb;
  logic        hilo_we, hilo_sel;
  logic [31:0] hilo_wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srca(srca), .srcb(srcb),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one edge; returns 1 time unit after the accepting edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srca = a; srcb = b; start = 1'b1;
    step();
    start = 1'b0;
    srca = 32'h0; srcb = 32'h0;
  endtask

  // Waits for done (bounded), optionally pulsing start+hilo_we at cycle disturb_at.
  task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int disturb_at);
    int cycles = 0;
    int nbusy = 0;
    logic [31:0] hi0 = hi, lo0 = lo;
    check({tag, " busy_after_start"}, {31'h0, busy}, 32'h1);
    while (!done && cycles < 100) begin
      if (busy) nbusy++;
      if (cycles == 20) begin
        check({tag, " hi_stable_calc"}, hi, hi0);
        check({tag, " lo_stable_calc"}, lo, lo0);
      end
      if (cycles == disturb_at) begin
        start = 1'b1; op = 2'd3; srca = 32'd100; srcb = 32'd3;
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hDEADBEEF;
        step();
        start = 1'b0; hilo_we = 1'b0;
      end else begin
        step();
      end
      cycles++;
    end
    check({tag, " latency"}, cycles, 32'd33);
    check({tag, " busy_cycles"}, nbusy, 32'd33);
    check({tag, " busy_at_done"}, {31'h0, busy}, 32'h0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; op = 2'd0; srca = 0; srcb = 0;
    hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = 0;
    step(); step();
    reset = 1'b0;
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);

    start_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", 32'hFFFFFFFE, 32'h00000001, -1);
    step();
    check("done_one_cycle", {31'h0, done}, 32'h0);

    start_op(2'd0, 32'hFFFFFFFD, 32'd5);
    wait_done("mult_neg3x5", 32'hFFFFFFFF, 32'hFFFFFFF1, -1);
    start_op(2'd0, 32'h80000000, 32'h80000000);
    wait_done("mult_minxmin", 32'h40000000, 32'h00000000, -1);
    start_op(2'd2, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg7by2", 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
    start_op(2'd3, 32'd7, 32'd2);
    wait_done("divu_7by2", 32'd1, 32'd3, -1);
    start_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_wrap", 32'h0, 32'h80000000, -1);
    start_op(2'd2, 32'hFFFFFFF0, 32'h0);
    wait_done("div_by0", 32'hFFFFFFF0, 32'hFFFFFFFF, -1);
    start_op(2'd3, 32'h1234, 32'h0);
    wait_done("divu_by0", 32'h1234, 32'hFFFFFFFF, -1);
    step();

    // Direct writes in IDLE
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hA5A5A5A5;
    step();
    hilo_we = 1'b0;
    check("mtlo lo", lo, 32'hA5A5A5A5);
    check("mtlo hi_kept", hi, 32'h1234);
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h5A5A5A5A;
    step();
    hilo_we = 1'b0;
    check("mthi hi", hi, 32'h5A5A5A5A);

    // start and direct write pulsed mid-operation are ignored
    start_op(2'd1, 32'd6, 32'd7);
    wait_done("multu_disturbed", 32'h0, 32'd42, 5);

    // start wins over a same-cycle direct write
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h11111111;
    start_op(2'd1, 32'd2, 32'd3);
    hilo_we = 1'b0;
    check("start_wins hi_kept", hi, 32'h0);
    wait_done("multu_2x3", 32'h0, 32'd6, -1);

    // back-to-back: start issued in the done cycle
    start_op(2'd3, 32'd100, 32'd7);
    check("b2b done_cleared", {31'h0, done}, 32'h0);
    wait_done("divu_b2b", 32'd2, 32'd14, -1);

    // reset at CALC iteration 10
    start_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset busy", {31'h0, busy}, 32'h0);
    check("midreset done", {31'h0, done}, 32'h0);
    check("midreset hi", hi, 32'h0);
    check("midreset lo", lo, 32'h0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen_done++;
      step();
    end
    check("midreset no_activity", seen_done, 32'd0);
    start_op(2'd0, 32'hFFFFFFFD, 32'd5);
    wait_done("after_reset_mult", 32'hFFFFFFFF, 32'hFFFFFFF1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the multi-cycle MIPS core, executing MULT, MULTU, DIV and DIVU and holding the architectural HI/LO registers. It sits in the datapath beside the ALU: it takes operands from the A/B register outputs and a start/op command from the control FSM. It returns `busy` so the FSM holds in a wait state, and supplies HI/LO for MFHI/MFLO. MTHI/MTLO write through a direct port.

## Interface
- `WIDTH`, 32, operand/HI/LO width. The iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  command strobe, sampled only in IDLE.
- `op`  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with `start`.
- `srca`  in  WIDTH  multiplicand / dividend (rs).
- `srcb`  in  WIDTH  multiplier / divisor (rt).
- `hilo_we`  in  1  direct write strobe (MTHI/MTLO).
- `hilo_sel`  in  1  0=LO, 1=HI, target of the direct write.
- `hilo_wdata`  in  WIDTH  direct write data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result this cycle.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers.

## Operation
- States:
  - IDLE → CALC on `start`.
  - CALC runs `WIDTH` iterations, counter 0..WIDTH-1, then → FIX.
  - FIX → IDLE unconditionally.
- On accept, latch op. Signed ops latch operand magnitudes and the signs of `srca`/`srcb`. Unsigned ops latch operands as-is.
- Multiply: shift-add, one multiplier bit per CALC cycle, 2·WIDTH-bit product.
- Divide: restoring, one quotient bit per CALC cycle.
- Result sign fix, applied in FIX:
  - MULT: negate the 64-bit product if the signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Results are loaded into HI/LO at the FIX edge:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero, DIV or DIVU: HI = original `srca`, LO = all ones. No sign fix. Same latency.
- DIV of 0x80000000 by 0xFFFFFFFF wraps: LO = 0x80000000, HI = 0.
- Direct write in IDLE updates the selected register at that edge.
- Direct write while `busy` is ignored.
- `start` while `busy` is ignored.
- `start` and `hilo_we` in the same IDLE cycle: `start` wins and the write is dropped.
- All arithmetic is modulo 2^WIDTH per register. Negation is two's complement. The 64-bit negate carries across halves.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- `start` sampled at edge E:
  - `busy`=1 from E through E+WIDTH+1, i.e. 33 cycles at WIDTH=32.
  - HI/LO are updated and `done`=1 after edge E+WIDTH+1, for exactly one cycle.
  - `busy`=0 in that same cycle.
- A new `start` is accepted in the cycle `done` is high, so back-to-back operations are possible.
- `busy` and `done` are registered outputs, never combinational from inputs.
- HI/LO are unchanged during CALC. Intermediate values live in internal accumulators only.
- Reset asserted mid-operation: next cycle is IDLE with all outputs at their reset values. No `done`, no partial result.

## Structure
- Shared package `muldiv_pkg`:
  - `mdu_op_t` enum: MULT, MULTU, DIV, DIVU.
  - `mdu_state_t` enum: IDLE, CALC, FIX.
  - Default WIDTH constant.
- The control FSM and the instruction decoder import `mdu_op_t` from this package.
- Single module, no sub-module. The multiply and divide iterations share one 2·WIDTH accumulator and one counter.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, `done` exactly 33 cycles after the start edge, `busy` high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 → LO=3, HI=1.
- Divides with boundary operands:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 0x1234 / 0 → HI=0x1234, LO=0xFFFFFFFF.
- Command/write arbitration, direct writes:
  - `start` and `hilo_we` pulsed mid-operation → ignored; result matches the original op.
  - MTLO 0xA5A5A5A5 in IDLE → `lo`=0xA5A5A5A5 the next cycle.
  - `start` with `hilo_we` in the same cycle → write dropped.
- Reset held one cycle at CALC iteration 10 → next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse. A subsequent op completes correctly.
